hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, 5, register-address width; NREG = 2**REG_AW.
REQ-002 SHALL have parameter LOAD_LAT, 1, cycles a load result is unforwardable after issue (legal 1..7; 3-bit counters).
REQ-003 SHALL have ports: clk  in  1  clock, all state on rising edge; rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: id_valid  in  1  ID holds a real instruction; id_rs, id_rt  in  REG_AW  source addresses; id_rs_used, id_rt_used  in  1  source read flags.
REQ-005 SHALL have ports: id_wreg  in  1  writes a register; id_waddr  in  REG_AW  destination; id_is_load  in  1  load; id_branch_taken  in  1  branch/jump redirect resolved in ID.
REQ-006 SHALL have ports: exe_waddr, mem_waddr  in  REG_AW; exe_wreg, exe_mem2reg, mem_wreg, mem_mem2reg  in  1  downstream write info; ext_stall  in  1  memory-system freeze.
REQ-007 SHALL have ports: stall  out  1  hold PC/IF/ID, bubble EXE; flush  out  1  squash IF instruction; fwda, fwdb  out  2  operand select (00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data); sb_busy  out  NREG  per-register pending-load flag.

Function
REQ-008 SHALL keep one LOAD_LAT-wide-enough (3-bit) down-counter cnt[r] per register r; sb_busy[r] = (cnt[r] != 0), combinational from registers.
REQ-009 SHALL define issue = id_valid & !stall & !ext_stall.
REQ-010 SHALL load cnt[id_waddr] = LOAD_LAT on a clock edge when issue & id_is_load & id_wreg & id_waddr != 0.
REQ-011 SHALL, on every other edge with ext_stall = 0, decrement each nonzero cnt by 1, saturating at 0; a same-edge load of REQ-010 wins over decrement for that register.
REQ-012 SHALL hold all cnt unchanged while ext_stall = 1.
REQ-013 SHALL assert stall combinationally when id_valid and ((id_rs_used & id_rs != 0 & cnt[id_rs] != 0) or (id_rt_used & id_rt != 0 & cnt[id_rt] != 0)); register 0 never stalls.
REQ-014 SHALL compute fwda combinationally, only if id_rs_used & id_rs != 0: 01 if exe_wreg & !exe_mem2reg & exe_waddr == id_rs; else 10 if mem_wreg & !mem_mem2reg & mem_waddr == id_rs; else 11 if mem_wreg & mem_mem2reg & mem_waddr == id_rs; else 00. fwdb identical on id_rt/id_rt_used.
REQ-015 SHALL register flush: flush <= issue & id_branch_taken; flush is high exactly one cycle after the issuing edge unless ext_stall is high, in which case flush holds its value.
REQ-016 SHALL NOT set flush for a branch that is stalled (stall = 1); it is evaluated again when it issues.
REQ-017 SHALL produce stall = 0 and fwda = fwdb = 00 when id_valid = 0 (fwd additionally forced 00).
REQ-018 With LOAD_LAT = 1, load followed immediately by a dependent instruction SHALL give exactly one stall cycle, then fwd = 11.

Reset
REQ-019 SHALL, on a clock edge with rst_n = 0, clear all cnt, flush and sb_busy to 0, overriding any simultaneous issue or ext_stall.
REQ-020 SHALL make stall = 0 on the first cycle after reset regardless of pre-reset pending loads.

Configuration
REQ-021 SHALL, when macro HAZARD_PERF_CNT_EN is defined, add outputs perf_stall_cnt and perf_flush_cnt (out, 32 each) counting cycles with stall & !ext_stall and cycles with flush = 1, wrapping at 2**32, reset to 0 by rst_n.
REQ-022 SHALL, without HAZARD_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-023 LOAD_LAT=1: lw r8 issues; next ID add r9,r8,r2 -> stall=1 one cycle, sb_busy[8]=1, next cycle stall=0, fwda=11.
REQ-024 LOAD_LAT=3: lw r8 issues; dependent consumer waits -> stall high 3 cycles; ext_stall=1 for 2 of them -> stall high 5 cycles total.
REQ-025 lw r0 then consumer of r0 -> no stall, sb_busy all 0, fwda=00.
REQ-026 beq taken issues with id_valid=1, stall=0 -> flush=1 next cycle only; same beq with rs load-pending -> flush only after stall clears.
REQ-027 exe_waddr=mem_waddr=5, exe_wreg=mem_wreg=1, mem_mem2reg=1, consumer rs=5 -> fwda=01; rst_n=0 mid-stall -> next cycle stall=0, flush=0, perf counters 0 (with HAZARD_PERF_CNT_EN).

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard for a 5-stage pipeline: per-register pending-load counters, stall/flush and forwarding selects.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    localparam int NREG    = 2**REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              id_branch_taken,
    input  logic [REG_AW-1:0] exe_waddr,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic              exe_wreg,
    input  logic              exe_mem2reg,
    input  logic              mem_wreg,
    input  logic              mem_mem2reg,
    input  logic              ext_stall,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic [NREG-1:0]   sb_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic [2:0] cnt [NREG];
    logic       rs_busy;
    logic       rt_busy;
    logic       issue;
    logic       load_set;

    function automatic logic [1:0] fwd_sel(
        input logic              valid,
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              e_wreg,
        input logic              e_m2r,
        input logic [REG_AW-1:0] e_waddr,
        input logic              m_wreg,
        input logic              m_m2r,
        input logic [REG_AW-1:0] m_waddr
    );
        if (!valid || !used || src == '0)               return 2'b00;
        if (e_wreg && !e_m2r && e_waddr == src)         return 2'b01;
        if (m_wreg && !m_m2r && m_waddr == src)         return 2'b10;
        if (m_wreg && m_m2r && m_waddr == src)          return 2'b11;
        return 2'b00;
    endfunction

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        rs_busy = id_rs_used && (id_rs != '0) && (cnt[id_rs] != 3'd0);
        rt_busy = id_rt_used && (id_rt != '0) && (cnt[id_rt] != 3'd0);
        stall   = id_valid && (rs_busy || rt_busy);
        for (int r = 0; r < NREG; r++) begin
            sb_busy[r] = (cnt[r] != 3'd0);
        end
    end

    assign issue    = id_valid & ~stall & ~ext_stall;
    assign load_set = issue & id_is_load & id_wreg & (id_waddr != '0);

    assign fwda = fwd_sel(id_valid, id_rs_used, id_rs, exe_wreg, exe_mem2reg, exe_waddr,
                          mem_wreg, mem_mem2reg, mem_waddr);
    assign fwdb = fwd_sel(id_valid, id_rt_used, id_rt, exe_wreg, exe_mem2reg, exe_waddr,
                          mem_wreg, mem_mem2reg, mem_waddr);

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the counter array is reset explicitly; pending loads must not survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 3'd0;
            end
            flush <= 1'b0;
        end else if (!ext_stall) begin
            for (int r = 0; r < NREG; r++) begin
                if (load_set && id_waddr == REG_AW'(r)) begin
                    cnt[r] <= 3'(LOAD_LAT);
                end else if (cnt[r] != 3'd0) begin
                    cnt[r] <= cnt[r] - 3'd1;
                end
            end
            flush <= issue & id_branch_taken;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall && !ext_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush)               perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: two instances (LOAD_LAT 1 and 3) on shared stimulus,
// directed scenarios plus randomized cycles against a timestamp-based reference model.
module tb_hazard_scoreboard;

    localparam int AW   = 5;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_rs_used, id_rt_used, id_wreg, id_is_load, id_branch_taken;
    logic [AW-1:0] id_rs, id_rt, id_waddr, exe_waddr, mem_waddr;
    logic          exe_wreg, exe_mem2reg, mem_wreg, mem_mem2reg, ext_stall;

    logic            stall1, stall3, flush1, flush3;
    logic [1:0]      fwda1, fwda3, fwdb1, fwdb3;
    logic [NREG-1:0] busy1, busy3;
    logic [31:0]     pst1, pst3, pfl1, pfl3;

    int checks = 0;
    int errors = 0;

    // Reference model: a register is busy while its ready timestamp lies ahead of the
    // count of unfrozen clock edges seen by that instance.
    int unsigned tick  [2];
    int unsigned ready [2][NREG];
    logic        m_flush [2];
    logic [31:0] m_pst [2];
    logic [31:0] m_pfl [2];

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(AW), .LOAD_LAT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .exe_waddr(exe_waddr),
        .mem_waddr(mem_waddr), .exe_wreg(exe_wreg), .exe_mem2reg(exe_mem2reg), .mem_wreg(mem_wreg),
        .mem_mem2reg(mem_mem2reg), .ext_stall(ext_stall), .stall(stall1), .flush(flush1),
        .fwda(fwda1), .fwdb(fwdb1), .sb_busy(busy1)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(pst1), .perf_flush_cnt(pfl1)
`endif
    );

    hazard_scoreboard #(.REG_AW(AW), .LOAD_LAT(3)) d3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .exe_waddr(exe_waddr),
        .mem_waddr(mem_waddr), .exe_wreg(exe_wreg), .exe_mem2reg(exe_mem2reg), .mem_wreg(mem_wreg),
        .mem_mem2reg(mem_mem2reg), .ext_stall(ext_stall), .stall(stall3), .flush(flush3),
        .fwda(fwda3), .fwdb(fwdb3), .sb_busy(busy3)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(pst3), .perf_flush_cnt(pfl3)
`endif
    );

`ifndef HAZARD_PERF_CNT_EN
    assign pst1 = '0;
    assign pst3 = '0;
    assign pfl1 = '0;
    assign pfl3 = '0;
`endif

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic a_stall(int k);            return (k == 0) ? stall1 : stall3; endfunction
    function automatic logic a_flush(int k);            return (k == 0) ? flush1 : flush3; endfunction
    function automatic logic [1:0] a_fwda(int k);       return (k == 0) ? fwda1 : fwda3;   endfunction
    function automatic logic [1:0] a_fwdb(int k);       return (k == 0) ? fwdb1 : fwdb3;   endfunction
    function automatic logic [NREG-1:0] a_busy(int k);  return (k == 0) ? busy1 : busy3;   endfunction
    function automatic logic [31:0] a_pst(int k);       return (k == 0) ? pst1 : pst3;     endfunction
    function automatic logic [31:0] a_pfl(int k);       return (k == 0) ? pfl1 : pfl3;     endfunction

    function automatic logic m_busy(int k, logic [AW-1:0] r);
        return ready[k][r] > tick[k];
    endfunction

    function automatic logic [NREG-1:0] m_busy_vec(int k);
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy(k, AW'(r));
        return v;
    endfunction

    function automatic logic m_stall(int k);
        return id_valid && ((id_rs_used && id_rs != 0 && m_busy(k, id_rs)) ||
                            (id_rt_used && id_rt != 0 && m_busy(k, id_rt)));
    endfunction

    function automatic logic [1:0] m_fwd(logic used, logic [AW-1:0] src);
        if (!id_valid || !used || src == 0)                     return 2'b00;
        if (exe_wreg && !exe_mem2reg && exe_waddr == src)       return 2'b01;
        if (mem_wreg && !mem_mem2reg && mem_waddr == src)       return 2'b10;
        if (mem_wreg && mem_mem2reg && mem_waddr == src)        return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic st;
            st = m_stall(k);
            if (!rst_n) begin
                for (int r = 0; r < NREG; r++) ready[k][r] = 0;
                m_flush[k] = 1'b0;
                m_pst[k]   = 32'd0;
                m_pfl[k]   = 32'd0;
            end else begin
                if (st && !ext_stall) m_pst[k] = m_pst[k] + 32'd1;
                if (m_flush[k])       m_pfl[k] = m_pfl[k] + 32'd1;
                if (!ext_stall) begin
                    if (id_valid && !st && id_is_load && id_wreg && id_waddr != 0)
                        ready[k][id_waddr] = tick[k] + 1 + lat_of(k);
                    m_flush[k] = id_valid && !st && id_branch_taken;
                    tick[k]    = tick[k] + 1;
                end
            end
        end
    endtask

    // Inputs are settled before this is called; the model steps, then the DUTs see the edge.
    task automatic advance();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_wreg = 0; id_waddr = 0; id_is_load = 0; id_branch_taken = 0;
        exe_waddr = 0; mem_waddr = 0; exe_wreg = 0; exe_mem2reg = 0;
        mem_wreg = 0; mem_mem2reg = 0; ext_stall = 0;
    endtask

    task automatic drain(int n);
        set_idle();
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic drive_load(logic [AW-1:0] rd);
        set_idle();
        id_valid = 1; id_wreg = 1; id_is_load = 1; id_waddr = rd;
    endtask

    task automatic drive_consumer(logic [AW-1:0] rs, logic [AW-1:0] rt);
        set_idle();
        id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = 1; id_rt_used = 1;
        id_wreg = 1; id_waddr = 5'd9;
    endtask

    task automatic test_reset();
        rst_n = 0;
        id_valid = 1; id_rs = 5'd8; id_rt = 5'd8; id_rs_used = 1; id_rt_used = 1;
        id_wreg = 1; id_waddr = 5'd8; id_is_load = 1; id_branch_taken = 1;
        exe_waddr = 0; mem_waddr = 0; exe_wreg = 0; exe_mem2reg = 0;
        mem_wreg = 0; mem_mem2reg = 0; ext_stall = 1;
        advance();
        advance();
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (a_stall(k) !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b expected 0", k, a_stall(k)); end
            if (a_flush(k) !== 1'b0) begin errors++; $display("FAIL reset_flush[%0d]: got %b expected 0", k, a_flush(k)); end
            if (a_busy(k) !== '0)    begin errors++; $display("FAIL reset_busy[%0d]: got %h expected 0", k, a_busy(k)); end
        end
        drain(1);
    endtask

    task automatic test_load_use();
        drive_load(5'd8);
        checks += 2;
        if (stall1 !== 1'b0 || stall3 !== 1'b0) begin errors++; $display("FAIL lu_load_issue: got %b%b expected 00", stall1, stall3); end
        if (busy3 !== '0) begin errors++; $display("FAIL lu_pre_busy: got %h expected 0", busy3); end
        advance();
        drive_consumer(5'd8, 5'd2);
        exe_wreg = 1; exe_mem2reg = 1; exe_waddr = 5'd8;
        #1;
        checks += 4;
        if (stall1 !== 1'b1)   begin errors++; $display("FAIL lu_stall1: got %b expected 1", stall1); end
        if (busy1[8] !== 1'b1) begin errors++; $display("FAIL lu_busy8: got %b expected 1", busy1[8]); end
        if (fwda1 !== 2'b00)   begin errors++; $display("FAIL lu_fwda_exe_load: got %b expected 00", fwda1); end
        if (stall3 !== 1'b1)   begin errors++; $display("FAIL lu_stall3_c0: got %b expected 1", stall3); end
        advance();
        drive_consumer(5'd8, 5'd2);
        mem_wreg = 1; mem_mem2reg = 1; mem_waddr = 5'd8;
        #1;
        checks += 3;
        if (stall1 !== 1'b0) begin errors++; $display("FAIL lu_stall1_release: got %b expected 0", stall1); end
        if (fwda1 !== 2'b11) begin errors++; $display("FAIL lu_fwda_mem_load: got %b expected 11", fwda1); end
        if (stall3 !== 1'b1) begin errors++; $display("FAIL lu_stall3_c1: got %b expected 1", stall3); end
        advance();
        drain(4);
    endtask

    task automatic test_ext_stall();
        int  c1 = 0;
        int  c3 = 0;
        logic done = 0;
        drive_load(5'd8);
        advance();
        for (int i = 0; i < 20; i++) begin
            drive_consumer(5'd8, 5'd0);
            ext_stall = (i == 1 || i == 2);
            #1;
            if (stall1) c1++;
            if (!stall3) begin done = 1; break; end
            c3++;
            advance();
        end
        checks += 3;
        if (!done)    begin errors++; $display("FAIL ext_timeout: stall3 still high after 20 cycles"); end
        if (c3 !== 5) begin errors++; $display("FAIL ext_stall3_cycles: got %0d expected 5", c3); end
        if (c1 !== 1) begin errors++; $display("FAIL ext_stall1_cycles: got %0d expected 1", c1); end
        advance();
        drain(4);
    endtask

    task automatic test_r0();
        drive_load(5'd0);
        advance();
        drive_consumer(5'd0, 5'd0);
        exe_wreg = 1; exe_mem2reg = 1; exe_waddr = 5'd0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (a_stall(k) !== 1'b0)  begin errors++; $display("FAIL r0_stall[%0d]: got %b expected 0", k, a_stall(k)); end
            if (a_busy(k) !== '0)     begin errors++; $display("FAIL r0_busy[%0d]: got %h expected 0", k, a_busy(k)); end
            if (a_fwda(k) !== 2'b00)  begin errors++; $display("FAIL r0_fwda[%0d]: got %b expected 00", k, a_fwda(k)); end
        end
        advance();
        drain(1);
    endtask

    task automatic test_branch_flush();
        int   n = 0;
        logic done = 0;
        set_idle();
        id_valid = 1; id_rs = 5'd3; id_rt = 5'd4; id_rs_used = 1; id_rt_used = 1; id_branch_taken = 1;
        #1;
        checks += 2;
        if (stall1 !== 1'b0 || stall3 !== 1'b0) begin errors++; $display("FAIL br_stall: got %b%b expected 00", stall1, stall3); end
        if (flush1 !== 1'b0 || flush3 !== 1'b0) begin errors++; $display("FAIL br_flush_before: got %b%b expected 00", flush1, flush3); end
        advance();
        set_idle();
        #1;
        checks++;
        if (flush1 !== 1'b1 || flush3 !== 1'b1) begin errors++; $display("FAIL br_flush_next: got %b%b expected 11", flush1, flush3); end
        advance();
        checks++;
        if (flush1 !== 1'b0 || flush3 !== 1'b0) begin errors++; $display("FAIL br_flush_once: got %b%b expected 00", flush1, flush3); end

        drive_load(5'd3);
        advance();
        for (int i = 0; i < 20; i++) begin
            set_idle();
            id_valid = 1; id_rs = 5'd3; id_rs_used = 1; id_branch_taken = 1;
            #1;
            if (!stall3) begin done = 1; break; end
            n++;
            checks++;
            if (flush3 !== 1'b0) begin errors++; $display("FAIL br_flush_while_stalled c%0d: got %b expected 0", i, flush3); end
            advance();
        end
        checks += 2;
        if (!done)   begin errors++; $display("FAIL br_timeout: stall3 still high after 20 cycles"); end
        if (n !== 3) begin errors++; $display("FAIL br_stall_cycles: got %0d expected 3", n); end
        advance();
        set_idle();
        #1;
        checks++;
        if (flush3 !== 1'b1) begin errors++; $display("FAIL br_flush_after_stall: got %b expected 1", flush3); end
        advance();
        checks++;
        if (flush3 !== 1'b0) begin errors++; $display("FAIL br_flush_after_once: got %b expected 0", flush3); end
        drain(2);
    endtask

    task automatic test_forward();
        logic [5:0] ctl [6];
        logic [1:0] exp [6];
        // ctl bits: valid, rs/rt used, exe_wreg, exe_mem2reg, mem_wreg, mem_mem2reg
        ctl = '{6'b111011, 6'b110011, 6'b110010, 6'b111110, 6'b011011, 6'b101011};
        exp = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};
        for (int i = 0; i < 6; i++) begin
            set_idle();
            id_rs = 5'd5; id_rt = 5'd5; exe_waddr = 5'd5; mem_waddr = 5'd5;
            {id_valid, id_rs_used, exe_wreg, exe_mem2reg, mem_wreg, mem_mem2reg} = ctl[i];
            id_rt_used = id_rs_used;
            #1;
            for (int k = 0; k < 2; k++) begin
                checks += 2;
                if (a_fwda(k) !== exp[i]) begin errors++; $display("FAIL fwd_row%0d_a[%0d]: got %b expected %b", i, k, a_fwda(k), exp[i]); end
                if (a_fwdb(k) !== exp[i]) begin errors++; $display("FAIL fwd_row%0d_b[%0d]: got %b expected %b", i, k, a_fwdb(k), exp[i]); end
            end
            advance();
        end
        drain(1);
    endtask

    task automatic test_reset_mid_stall();
        drive_load(5'd8);
        advance();
        drive_consumer(5'd8, 5'd8);
        id_branch_taken = 1;
        #1;
        checks++;
        if (stall3 !== 1'b1) begin errors++; $display("FAIL rms_pre_stall: got %b expected 1", stall3); end
        rst_n = 0;
        advance();
        rst_n = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (a_stall(k) !== 1'b0) begin errors++; $display("FAIL rms_stall[%0d]: got %b expected 0", k, a_stall(k)); end
            if (a_flush(k) !== 1'b0) begin errors++; $display("FAIL rms_flush[%0d]: got %b expected 0", k, a_flush(k)); end
            if (a_busy(k) !== '0)    begin errors++; $display("FAIL rms_busy[%0d]: got %h expected 0", k, a_busy(k)); end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            if (a_pst(k) !== 32'd0 || a_pfl(k) !== 32'd0) begin
                errors++; $display("FAIL rms_perf[%0d]: got %0d/%0d expected 0/0", k, a_pst(k), a_pfl(k));
            end
`endif
        end
        drain(1);
    endtask

    task automatic test_random(int n);
        for (int c = 0; c < n; c++) begin
            rst_n           = ($urandom_range(0, 99) != 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = AW'($urandom_range(0, 7));
            id_rt           = AW'($urandom_range(0, 7));
            id_rs_used      = $urandom_range(0, 1);
            id_rt_used      = $urandom_range(0, 1);
            id_wreg         = $urandom_range(0, 1);
            id_waddr        = AW'($urandom_range(0, 7));
            id_is_load      = ($urandom_range(0, 2) == 0);
            id_branch_taken = ($urandom_range(0, 4) == 0);
            exe_waddr       = AW'($urandom_range(0, 7));
            mem_waddr       = AW'($urandom_range(0, 7));
            exe_wreg        = $urandom_range(0, 1);
            exe_mem2reg     = $urandom_range(0, 1);
            mem_wreg        = $urandom_range(0, 1);
            mem_mem2reg     = $urandom_range(0, 1);
            ext_stall       = ($urandom_range(0, 4) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks += 5;
                if (a_stall(k) !== m_stall(k)) begin errors++; $display("FAIL rnd_stall[%0d] c%0d: got %b expected %b", k, c, a_stall(k), m_stall(k)); end
                if (a_flush(k) !== m_flush[k]) begin errors++; $display("FAIL rnd_flush[%0d] c%0d: got %b expected %b", k, c, a_flush(k), m_flush[k]); end
                if (a_fwda(k) !== m_fwd(id_rs_used, id_rs)) begin errors++; $display("FAIL rnd_fwda[%0d] c%0d: got %b expected %b", k, c, a_fwda(k), m_fwd(id_rs_used, id_rs)); end
                if (a_fwdb(k) !== m_fwd(id_rt_used, id_rt)) begin errors++; $display("FAIL rnd_fwdb[%0d] c%0d: got %b expected %b", k, c, a_fwdb(k), m_fwd(id_rt_used, id_rt)); end
                if (a_busy(k) !== m_busy_vec(k)) begin errors++; $display("FAIL rnd_busy[%0d] c%0d: got %h expected %h", k, c, a_busy(k), m_busy_vec(k)); end
`ifdef HAZARD_PERF_CNT_EN
                checks++;
                if (a_pst(k) !== m_pst[k] || a_pfl(k) !== m_pfl[k]) begin
                    errors++; $display("FAIL rnd_perf[%0d] c%0d: got %0d/%0d expected %0d/%0d", k, c, a_pst(k), a_pfl(k), m_pst[k], m_pfl[k]);
                end
`endif
            end
            advance();
        end
        drain(4);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            tick[k] = 0; m_flush[k] = 0; m_pst[k] = 0; m_pfl[k] = 0;
            for (int r = 0; r < NREG; r++) ready[k][r] = 0;
        end
        set_idle();
        @(negedge clk);
        #1;
        test_reset();
        test_load_use();
        test_ext_stall();
        test_r0();
        test_branch_flush();
        test_forward();
        test_reset_mid_stall();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
